hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 144 ++++++++++++++
 tb/tb_hazard_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard unit for a 5-stage pipeline: tracks E/M/W in shadow registers and drives stall,
// flush and forwarding controls. Define HAZARD_FORWARD_EN for bypassing; otherwise RAW stalls.
module hazard_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic             UseA1D,
  input  logic             UseA2D,
  input  logic [3:0]       WA3D,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             PCWriteD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] StallCnt
);

  typedef struct packed {
    logic       valid;
    logic [3:0] wa3;
    logic       regwrite;
    logic       memtoreg;
    logic       pcwrite;
  } stage_t;

  // R15 reads return PC+8, so no stage ever supplies it.
  function automatic logic writes_reg(input stage_t s, input logic [3:0] n);
    return s.valid & s.regwrite & (s.wa3 == n) & (n != 4'd15);
  endfunction

  stage_t           e_q, e_d, m_q, w_q;
  logic [3:0]       e_ra1_q, e_ra1_d, e_ra2_q, e_ra2_d;
  logic             e_usea1_q, e_usea1_d, e_usea2_q, e_usea2_d;
  logic             valid_d_q, valid_d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard_stall, pc_pend, pc_redir_w;

`ifdef HAZARD_FORWARD_EN
  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [3:0] src,
                                         input stage_t m, input stage_t w);
    if (use_src && writes_reg(m, src)) return 2'b10;
    if (use_src && writes_reg(w, src)) return 2'b01;
    return 2'b00;
  endfunction

  // Only a load in E cannot be bypassed in time.
  assign hazard_stall = valid_d_q & e_q.memtoreg &
                        ((UseA1D & writes_reg(e_q, RA1D)) | (UseA2D & writes_reg(e_q, RA2D)));
  assign ForwardAE    = fwd_sel(e_usea1_q, e_ra1_q, m_q, w_q);
  assign ForwardBE    = fwd_sel(e_usea2_q, e_ra2_q, m_q, w_q);

  logic unused_shadow;
  assign unused_shadow = ^{m_q.memtoreg, w_q.memtoreg};
`else
  function automatic logic pending_write(input logic use_src, input logic [3:0] src,
                                         input stage_t e, input stage_t m, input stage_t w);
    return use_src & (writes_reg(e, src) | writes_reg(m, src) | writes_reg(w, src));
  endfunction

  // Without bypassing, D waits until every older producer has left W.
  assign hazard_stall = valid_d_q & (pending_write(UseA1D, RA1D, e_q, m_q, w_q) |
                                     pending_write(UseA2D, RA2D, e_q, m_q, w_q));
  assign ForwardAE    = 2'b00;
  assign ForwardBE    = 2'b00;

  logic unused_shadow;
  assign unused_shadow = ^{e_q.memtoreg, m_q.memtoreg, w_q.memtoreg,
                           e_ra1_q, e_ra2_q, e_usea1_q, e_usea2_q};
`endif

  assign pc_pend    = (valid_d_q & PCWriteD) | (e_q.valid & e_q.pcwrite) |
                      (m_q.valid & m_q.pcwrite);
  assign pc_redir_w = w_q.valid & w_q.pcwrite;

  // A pending redirect overrides a stall: the Decode instruction is discarded instead.
  assign FlushD   = pc_pend | pc_redir_w;
  assign StallF   = (hazard_stall | pc_pend) & ~pc_redir_w;
  assign StallD   = hazard_stall & ~FlushD;
  assign FlushE   = hazard_stall | pc_redir_w | ~valid_d_q;
  assign StallCnt = cnt_q;

  always_comb begin
    e_d       = '0;
    e_ra1_d   = '0;
    e_ra2_d   = '0;
    e_usea1_d = 1'b0;
    e_usea2_d = 1'b0;
    if (!FlushE) begin
      e_d.valid    = valid_d_q;
      e_d.wa3      = WA3D;
      e_d.regwrite = RegWriteD;
      e_d.memtoreg = MemtoRegD;
      e_d.pcwrite  = PCWriteD;
      e_ra1_d      = RA1D;
      e_ra2_d      = RA2D;
      e_usea1_d    = UseA1D;
      e_usea2_d    = UseA2D;
    end

    valid_d_d = 1'b1;
    if (FlushD) begin
      valid_d_d = 1'b0;
    end else if (StallD) begin
      valid_d_d = valid_d_q;
    end

    cnt_d = cnt_q;
    if (StallD && (cnt_q != '1)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_d_q <= 1'b0;
      e_q       <= '0;
      m_q       <= '0;
      w_q       <= '0;
      e_ra1_q   <= '0;
      e_ra2_q   <= '0;
      e_usea1_q <= 1'b0;
      e_usea2_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_d_q <= valid_d_d;
      e_q       <= e_d;
      m_q       <= e_q;
      w_q       <= m_q;
      e_ra1_q   <= e_ra1_d;
      e_ra2_q   <= e_ra2_d;
      e_usea1_q <= e_usea1_d;
      e_usea2_q <= e_usea2_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: expected controls per cycle go through a scoreboard queue.
// Expectations follow HAZARD_FORWARD_EN; a second instance with CNT_W=4 checks saturation.
module tb_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  RA1D, RA2D, WA3D;
  logic        UseA1D, UseA2D, RegWriteD, MemtoRegD, PCWriteD;
  logic [1:0]  fa, fb, fa4, fb4;
  logic        sf, sd, fd, fe, sf4, sd4, fd4, fe4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  hazard_unit #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .UseA1D(UseA1D), .UseA2D(UseA2D),
    .WA3D(WA3D), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCWriteD(PCWriteD),
    .ForwardAE(fa), .ForwardBE(fb), .StallF(sf), .StallD(sd), .FlushD(fd), .FlushE(fe),
    .StallCnt(cnt)
  );

  hazard_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .UseA1D(UseA1D), .UseA2D(UseA2D),
    .WA3D(WA3D), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCWriteD(PCWriteD),
    .ForwardAE(fa4), .ForwardBE(fb4), .StallF(sf4), .StallD(sd4), .FlushD(fd4), .FlushE(fe4),
    .StallCnt(cnt4)
  );

  typedef struct packed {
    logic [3:0] ra1;
    logic       u1;
    logic [3:0] ra2;
    logic       u2;
    logic [3:0] wa3;
    logic       rw;
    logic       mtr;
    logic       pcw;
  } instr_t;

  typedef struct {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [3:0]  ctl;   // {StallF, StallD, FlushD, FlushE}
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   ecnt       = 0;

  function automatic instr_t mk(input logic [3:0] ra1, input logic u1, input logic [3:0] ra2,
                                input logic u2, input logic [3:0] wa3, input logic rw,
                                input logic mtr, input logic pcw);
    instr_t i;
    i.ra1 = ra1; i.u1 = u1; i.ra2 = ra2; i.u2 = u2;
    i.wa3 = wa3; i.rw = rw; i.mtr = mtr; i.pcw = pcw;
    return i;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one Decode slot, queue its expectation, compare on the falling edge.
  task automatic step(input string tag, input instr_t i, input logic [1:0] efa,
                      input logic [1:0] efb, input logic [3:0] ectl);
    exp_t e;
    RA1D = i.ra1; UseA1D = i.u1; RA2D = i.ra2; UseA2D = i.u2;
    WA3D = i.wa3; RegWriteD = i.rw; MemtoRegD = i.mtr; PCWriteD = i.pcw;
    e.fa   = efa;
    e.fb   = efb;
    e.ctl  = ectl;
    e.cnt  = ecnt[15:0];
    e.cnt4 = (ecnt > 15) ? 4'd15 : ecnt[3:0];
    sb.push_back(e);
    if (ectl[2]) ecnt++;
    @(negedge clk);
    e = sb.pop_front();
    check({tag, ".fwd"},  16'({fa, fb}), 16'({e.fa, e.fb}));
    check({tag, ".ctl"},  16'({sf, sd, fd, fe}), 16'(e.ctl));
    check({tag, ".ctl4"}, 16'({fa4, fb4, sf4, sd4, fd4, fe4}), 16'({e.fa, e.fb, e.ctl}));
    check({tag, ".cnt"},  cnt, e.cnt);
    check({tag, ".cnt4"}, 16'(cnt4), 16'(e.cnt4));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    ecnt  = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  instr_t nop, add_r1, sub_r2, ldr_r1, add_dep, ldr_r15, rd_r15, rd_nouse;
  instr_t wr_r5, rd_r5, br, junk, add_br, chain;

  initial begin
    nop      = '0;
    add_r1   = mk(4'd2, 1, 4'd3, 1, 4'd1, 1, 0, 0);
    sub_r2   = mk(4'd1, 1, 4'd3, 1, 4'd2, 1, 0, 0);
    ldr_r1   = mk(4'd4, 1, 4'd0, 0, 4'd1, 1, 1, 0);
    add_dep  = mk(4'd1, 1, 4'd1, 1, 4'd2, 1, 0, 0);
    ldr_r15  = mk(4'd0, 0, 4'd0, 0, 4'd15, 1, 1, 0);
    rd_r15   = mk(4'd1, 0, 4'd15, 1, 4'd3, 1, 0, 0);
    rd_nouse = mk(4'd3, 0, 4'd0, 0, 4'd0, 0, 0, 0);
    wr_r5    = mk(4'd0, 0, 4'd0, 0, 4'd5, 1, 0, 0);
    rd_r5    = mk(4'd6, 1, 4'd5, 1, 4'd7, 1, 0, 0);
    br       = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1);
    junk     = mk(4'd1, 1, 4'd1, 1, 4'd8, 1, 1, 0);
    add_br   = mk(4'd1, 1, 4'd0, 0, 4'd2, 1, 0, 1);
    chain    = mk(4'd1, 1, 4'd0, 0, 4'd1, 1, 1, 0);

    reset = 1'b1;
    RA1D = '0; RA2D = '0; WA3D = '0;
    UseA1D = 0; UseA2D = 0; RegWriteD = 0; MemtoRegD = 0; PCWriteD = 0;
    @(posedge clk);
    #1;

    // ALU result consumed back-to-back
    do_reset();
    step("a_rst", nop, 2'b00, 2'b00, 4'b0001);
    step("a_add", add_r1, 2'b00, 2'b00, 4'b0000);
`ifdef HAZARD_FORWARD_EN
    step("a_sub", sub_r2, 2'b00, 2'b00, 4'b0000);
    step("a_fwdm", nop, 2'b10, 2'b00, 4'b0000);
`else
    for (int k = 0; k < 3; k++) step("a_stall", sub_r2, 2'b00, 2'b00, 4'b1101);
    step("a_sub", sub_r2, 2'b00, 2'b00, 4'b0000);
    step("a_ex", nop, 2'b00, 2'b00, 4'b0000);
`endif
    step("a_tail", nop, 2'b00, 2'b00, 4'b0000);

    // Load followed by a dependent instruction
    do_reset();
    step("b_rst", nop, 2'b00, 2'b00, 4'b0001);
    step("b_ldr", ldr_r1, 2'b00, 2'b00, 4'b0000);
`ifdef HAZARD_FORWARD_EN
    step("b_stall", add_dep, 2'b00, 2'b00, 4'b1101);
    step("b_add", add_dep, 2'b00, 2'b00, 4'b0000);
    step("b_fwdw", nop, 2'b01, 2'b01, 4'b0000);
`else
    for (int k = 0; k < 3; k++) step("b_stall", add_dep, 2'b00, 2'b00, 4'b1101);
    step("b_add", add_dep, 2'b00, 2'b00, 4'b0000);
    step("b_ex", nop, 2'b00, 2'b00, 4'b0000);
`endif

    // R15 never matches; unused operands never stall or forward
    do_reset();
    step("c_rst", nop, 2'b00, 2'b00, 4'b0001);
    step("c_ldr15", ldr_r15, 2'b00, 2'b00, 4'b0000);
    step("c_rd15", rd_r15, 2'b00, 2'b00, 4'b0000);
    step("c_nouse", rd_nouse, 2'b00, 2'b00, 4'b0000);
    step("c_ex", nop, 2'b00, 2'b00, 4'b0000);

    // Two older writers of R5: M must win over W
    do_reset();
    step("d_rst", nop, 2'b00, 2'b00, 4'b0001);
    step("d_w1", wr_r5, 2'b00, 2'b00, 4'b0000);
    step("d_w2", wr_r5, 2'b00, 2'b00, 4'b0000);
`ifdef HAZARD_FORWARD_EN
    step("d_rd", rd_r5, 2'b00, 2'b00, 4'b0000);
    step("d_prio", nop, 2'b00, 2'b10, 4'b0000);
`else
    for (int k = 0; k < 3; k++) step("d_stall", rd_r5, 2'b00, 2'b00, 4'b1101);
    step("d_rd", rd_r5, 2'b00, 2'b00, 4'b0000);
    step("d_ex", nop, 2'b00, 2'b00, 4'b0000);
`endif

    // PC redirect penalty
    do_reset();
    step("e_rst", nop, 2'b00, 2'b00, 4'b0001);
    step("e_brd", br, 2'b00, 2'b00, 4'b1010);
    step("e_bre", junk, 2'b00, 2'b00, 4'b1011);
    step("e_brm", junk, 2'b00, 2'b00, 4'b1011);
    step("e_brw", junk, 2'b00, 2'b00, 4'b0011);
    step("e_bub", nop, 2'b00, 2'b00, 4'b0001);
    step("e_resume", nop, 2'b00, 2'b00, 4'b0000);

    // Load-use coinciding with a redirect in Decode: flush wins
    do_reset();
    step("f_rst", nop, 2'b00, 2'b00, 4'b0001);
    step("f_ldr", ldr_r1, 2'b00, 2'b00, 4'b0000);
    step("f_both", add_br, 2'b00, 2'b00, 4'b1011);
    step("f_bub", nop, 2'b00, 2'b00, 4'b0001);
    step("f_resume", nop, 2'b00, 2'b00, 4'b0000);

    // Reset during a load-use stall
    do_reset();
    step("g_rst", nop, 2'b00, 2'b00, 4'b0001);
    step("g_ldr", ldr_r1, 2'b00, 2'b00, 4'b0000);
    step("g_stall", add_dep, 2'b00, 2'b00, 4'b1101);
    do_reset();
    step("g_after", add_dep, 2'b00, 2'b00, 4'b0001);
    step("g_add", add_dep, 2'b00, 2'b00, 4'b0000);
    step("g_ex", nop, 2'b00, 2'b00, 4'b0000);

    // Reset during a redirect
    do_reset();
    step("h_rst", nop, 2'b00, 2'b00, 4'b0001);
    step("h_brd", br, 2'b00, 2'b00, 4'b1010);
    step("h_bre", nop, 2'b00, 2'b00, 4'b1011);
    do_reset();
    step("h_after", nop, 2'b00, 2'b00, 4'b0001);
    step("h_clean1", nop, 2'b00, 2'b00, 4'b0000);
    step("h_clean2", nop, 2'b00, 2'b00, 4'b0000);

    // Chain of dependent loads: counter passes 15, the 4-bit copy saturates
    do_reset();
    step("s_rst", nop, 2'b00, 2'b00, 4'b0001);
    step("s_first", chain, 2'b00, 2'b00, 4'b0000);
`ifdef HAZARD_FORWARD_EN
    for (int k = 0; k < 20; k++) begin
      step("s_stall", chain, (k == 0) ? 2'b00 : 2'b01, 2'b00, 4'b1101);
      step("s_go", chain, 2'b00, 2'b00, 4'b0000);
    end
    step("s_end", nop, 2'b01, 2'b00, 4'b0000);
`else
    for (int k = 0; k < 7; k++) begin
      for (int j = 0; j < 3; j++) step("s_stall", chain, 2'b00, 2'b00, 4'b1101);
      step("s_go", chain, 2'b00, 2'b00, 4'b0000);
    end
    step("s_end", nop, 2'b00, 2'b00, 4'b0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
